usb_tx_crc16_gen: RTL and testbench

Transmit-side USB CRC16 generator/serializer for DATA0/DATA1 payloads. It accepts payload bytes over a valid/ready handshake, shifts them out LSB-first, and accumulates CRC16 (poly 0x8005, init 0xFFFF). It then appends the complemented CRC, 16 bits MSB-first. It sits between the TX packet assembler and the bit stuffer/NRZI encoder; the bit stuffer's accept strobe paces it.

---
 rtl/usb_crc_pkg.sv | 21 ++
 rtl/usb_crc16_shadow.sv | 46 ++++
 rtl/usb_tx_crc16_gen.sv | 204 ++++++++++++++++++++
 tb/tb_usb_tx_crc16_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_crc_pkg.sv
// Shared constants, state encoding and serial CRC16 update for the USB TX CRC16 generator.
package usb_crc_pkg;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } tx_crc_state_t;

    // One serial step of the CRC16 polynomial division for a single transmitted bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_crc16_shadow.sv
// Receive-side CRC16 accumulator that re-checks every transmitted bit against the residual.
// Present only when USB_CRC16_GEN_SELFCHECK_EN is defined.
`ifdef USB_CRC16_GEN_SELFCHECK_EN
module usb_crc16_shadow
    import usb_crc_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic bit_in,
    input  logic take,
    input  logic finish,
    input  logic restart,
    output logic selfchk_err
);

    logic [15:0] acc_q, acc_d;
    logic        err_q, err_d;

    always_comb begin
        acc_d = acc_q;
        err_d = 1'b0;
        if (restart) begin
            acc_d = CRC16_INIT;
        end else if (finish) begin
            // The final CRC bit is folded in here so the residual check lines up with pkt_done.
            err_d = (crc16_step(acc_q, bit_in) != CRC16_RESIDUAL);
            acc_d = CRC16_INIT;
        end else if (take) begin
            acc_d = crc16_step(acc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= CRC16_INIT;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

    assign selfchk_err = err_q;

endmodule
`endif

// File: rtl/usb_tx_crc16_gen.sv
// USB DATA-packet serializer: shifts payload LSB-first, accumulates CRC16, appends the inverted CRC MSB-first.
// Optional shadow residual checker and selfchk_err port under USB_CRC16_GEN_SELFCHECK_EN.
module usb_tx_crc16_gen
    import usb_crc_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       tx_zlp,
    input  logic       abort,
    output logic       tx_bit,
    output logic       tx_bit_valid,
    input  logic       bit_strobe,
    output logic       crc_phase,
    output logic       pkt_done,
    output logic       underrun
`ifdef USB_CRC16_GEN_SELFCHECK_EN
    ,
    output logic       selfchk_err
`endif
);

    tx_crc_state_t state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_full_q, hold_full_d;
    logic          cur_last_q, cur_last_d;
    logic          lock_q, lock_d;
    logic [15:0]   crc_q, crc_d;
    logic          tx_bit_q, tx_bit_d;
    logic          tx_bit_valid_q, tx_bit_valid_d;
    logic          crc_phase_q, crc_phase_d;
    logic          pkt_done_q, pkt_done_d;
    logic          underrun_q, underrun_d;
    logic          accept;
    logic          strobe;
    logic          load_hold;

    // lock_q keeps the input closed once the final byte (or a ZLP) is committed.
    assign tx_ready = ~(hold_full_q | lock_q);
    assign accept   = tx_valid & tx_ready;
    assign strobe   = bit_strobe & tx_bit_valid_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        cur_last_d  = cur_last_q;
        lock_d      = lock_q;
        crc_d       = crc_q;
        pkt_done_d  = 1'b0;
        underrun_d  = 1'b0;
        load_hold   = 1'b0;

        case (state_q)
            IDLE: begin
                crc_d = CRC16_INIT;
                if (accept) begin
                    state_d    = DATA;
                    shift_d    = tx_data;
                    cnt_d      = 4'd0;
                    cur_last_d = tx_last;
                    lock_d     = tx_last;
                end else if (tx_zlp) begin
                    state_d = CRC;
                    cnt_d   = 4'd0;
                    lock_d  = 1'b1;
                end
            end
            DATA: begin
                load_hold = accept;
                if (strobe) begin
                    crc_d   = crc16_step(crc_q, shift_q[0]);
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (cur_last_q) begin
                            state_d = CRC;
                        end else if (hold_full_q) begin
                            shift_d     = hold_data_q;
                            cur_last_d  = hold_last_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            shift_d    = tx_data;
                            cur_last_d = tx_last;
                            load_hold  = 1'b0;
                        end else begin
                            state_d    = IDLE;
                            underrun_d = 1'b1;
                            crc_d      = CRC16_INIT;
                        end
                    end
                end
                if (load_hold) begin
                    hold_data_d = tx_data;
                    hold_last_d = tx_last;
                    hold_full_d = 1'b1;
                end
                if (accept && tx_last) begin
                    lock_d = 1'b1;
                end
            end
            CRC: begin
                if (strobe) begin
                    crc_d = {crc_q[14:0], 1'b0};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d    = IDLE;
                        pkt_done_d = 1'b1;
                        crc_d      = CRC16_INIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = CRC16_INIT;
            end
        endcase

        if (abort) begin
            state_d    = IDLE;
            crc_d      = CRC16_INIT;
            pkt_done_d = 1'b0;
            underrun_d = 1'b0;
        end

        if (state_d == IDLE) begin
            hold_full_d = 1'b0;
            cur_last_d  = 1'b0;
            lock_d      = 1'b0;
        end

        // Outputs are registered, so they are decoded from next-state values.
        tx_bit_valid_d = (state_d != IDLE);
        crc_phase_d    = (state_d == CRC);
        case (state_d)
            DATA:    tx_bit_d = shift_d[0];
            CRC:     tx_bit_d = ~crc_d[15];
            default: tx_bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            shift_q        <= 8'h00;
            cnt_q          <= 4'd0;
            hold_data_q    <= 8'h00;
            hold_last_q    <= 1'b0;
            hold_full_q    <= 1'b0;
            cur_last_q     <= 1'b0;
            lock_q         <= 1'b0;
            crc_q          <= CRC16_INIT;
            tx_bit_q       <= 1'b0;
            tx_bit_valid_q <= 1'b0;
            crc_phase_q    <= 1'b0;
            pkt_done_q     <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            hold_data_q    <= hold_data_d;
            hold_last_q    <= hold_last_d;
            hold_full_q    <= hold_full_d;
            cur_last_q     <= cur_last_d;
            lock_q         <= lock_d;
            crc_q          <= crc_d;
            tx_bit_q       <= tx_bit_d;
            tx_bit_valid_q <= tx_bit_valid_d;
            crc_phase_q    <= crc_phase_d;
            pkt_done_q     <= pkt_done_d;
            underrun_q     <= underrun_d;
        end
    end

    assign tx_bit       = tx_bit_q;
    assign tx_bit_valid = tx_bit_valid_q;
    assign crc_phase    = crc_phase_q;
    assign pkt_done     = pkt_done_q;
    assign underrun     = underrun_q;

`ifdef USB_CRC16_GEN_SELFCHECK_EN
    usb_crc16_shadow u_shadow (
        .clk         (clk),
        .n_rst       (n_rst),
        .bit_in      (tx_bit_q),
        .take        (strobe & ~abort),
        .finish      (pkt_done_d),
        .restart     (abort | underrun_d),
        .selfchk_err (selfchk_err)
    );
`endif

endmodule

// File: tb/tb_usb_tx_crc16_gen.sv
// Directed and randomized bench for usb_tx_crc16_gen, checked against a byte-wise reflected CRC16 model.
module tb_usb_tx_crc16_gen;
    import usb_crc_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       tx_zlp = 1'b0;
    logic       abort = 1'b0;
    logic       tx_bit;
    logic       tx_bit_valid;
    logic       bit_strobe = 1'b0;
    logic       crc_phase;
    logic       pkt_done;
    logic       underrun;
`ifdef USB_CRC16_GEN_SELFCHECK_EN
    logic       selfchk_err;
`endif

    int   checks = 0;
    int   failures = 0;
    logic [7:0] pkt_q[$];
    logic got_q[$];
    logic exp_q[$];
    bit   mark_last;
    int   crc_cycles, valid_cycles, stab_err;
    bit   saw_done, saw_underrun, saw_abort, saw_selfchk;

    usb_tx_crc16_gen dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .tx_zlp       (tx_zlp),
        .abort        (abort),
        .tx_bit       (tx_bit),
        .tx_bit_valid (tx_bit_valid),
        .bit_strobe   (bit_strobe),
        .crc_phase    (crc_phase),
        .pkt_done     (pkt_done),
        .underrun     (underrun)
`ifdef USB_CRC16_GEN_SELFCHECK_EN
        ,
        .selfchk_err  (selfchk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reflected, byte-at-a-time CRC16/USB; the returned word's bits go out LSB-first.
    function automatic logic [15:0] refCrcField();
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (pkt_q[i]) begin
            r = r ^ {8'h00, pkt_q[i]};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return ~r;
    endfunction

    task automatic buildExpected();
        logic [15:0] f;
        logic [7:0]  b;
        exp_q.delete();
        foreach (pkt_q[i]) begin
            b = pkt_q[i];
            for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        end
        f = refCrcField();
        for (int k = 0; k < 16; k++) exp_q.push_back(f[k]);
    endtask

    task automatic compareBits(input string tag);
        int diff;
        diff = -1;
        buildExpected();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (diff < 0 && got_q[i] !== exp_q[i]) diff = i;
        checkOutput({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        checkOutput({tag, "_first_diff"}, 32'(diff), 32'hFFFF_FFFF);
    endtask

    task automatic checkResidual(input string tag);
        logic [15:0] r;
        r = CRC16_INIT;
        foreach (got_q[i]) r = crc16_step(r, got_q[i]);
        checkOutput(tag, 32'(r), 32'(CRC16_RESIDUAL));
    endtask

    // Drives one packet from pkt_q, records every consumed bit; all driving/sampling on negedge.
    task automatic applyStimulus(input int period, input bit zlp, input int abort_at, input int flip_at);
        int cyc, idx, crc_taken, n;
        bit prev_v, prev_b, prev_s, did_abort;
        cyc = 0; idx = 0; crc_taken = 0; n = pkt_q.size();
        prev_v = 0; prev_b = 0; prev_s = 0; did_abort = 0;
        crc_cycles = 0; valid_cycles = 0; stab_err = 0;
        saw_done = 0; saw_underrun = 0; saw_abort = 0; saw_selfchk = 0;
        got_q.delete();
        @(negedge clk);
        while (cyc < 2000) begin
            if (pkt_done) begin
                saw_done = 1;
`ifdef USB_CRC16_GEN_SELFCHECK_EN
                saw_selfchk = selfchk_err;
`endif
                break;
            end
            if (underrun) begin
                saw_underrun = 1;
                break;
            end
            if (prev_v && !prev_s && tx_bit_valid && tx_bit !== prev_b) stab_err++;
            if (tx_bit_valid) valid_cycles++;
            if (crc_phase) crc_cycles++;
`ifdef USB_CRC16_GEN_SELFCHECK_EN
            if (crc_phase && crc_taken == flip_at && !prev_s) dut.crc_q[14] = ~dut.crc_q[14];
`endif
            tx_zlp     = zlp && (cyc == 0);
            tx_valid   = (idx < n) && (tx_ready || ($urandom_range(0, 1) == 1));
            tx_data    = tx_valid ? pkt_q[idx] : 8'($urandom);
            tx_last    = tx_valid && mark_last && (idx == n - 1);
            bit_strobe = (cyc % period) == 0;
            abort      = 1'b0;
            if (bit_strobe && tx_bit_valid) begin
                if (crc_phase && crc_taken == abort_at) abort = 1'b1;
                got_q.push_back(tx_bit);
                if (crc_phase) crc_taken++;
            end
            if (tx_valid && tx_ready && !abort) idx++;
            did_abort = abort;
            prev_v = tx_bit_valid; prev_b = tx_bit; prev_s = bit_strobe;
            @(negedge clk);
            cyc++;
            if (did_abort) begin
                saw_abort = 1;
                break;
            end
        end
        tx_valid = 0; tx_last = 0; tx_zlp = 0; bit_strobe = 0; abort = 0;
    endtask

    initial begin
        int dones;
        logic [7:0] cap;

        repeat (3) @(negedge clk);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_tx_bit", 32'(tx_bit), 32'd0);
        checkOutput("rst_tx_bit_valid", 32'(tx_bit_valid), 32'd0);
        checkOutput("rst_crc_phase", 32'(crc_phase), 32'd0);
        checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_crc", 32'(dut.crc_q), 32'hFFFF);
        n_rst = 1'b1;

        // Zero-length packet: sixteen zero bits, then pkt_done.
        pkt_q.delete(); mark_last = 1;
        applyStimulus(1, 1, -1, -1);
        checkOutput("zlp_done", 32'(saw_done), 32'd1);
        checkOutput("zlp_crc_cycles", 32'(crc_cycles), 32'd16);
        checkOutput("zlp_ready_at_done", 32'(tx_ready), 32'd1);
        compareBits("zlp_bits");

        // Bytes 00..03 with strobe every cycle: 48 bits with no bubbles.
        pkt_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        applyStimulus(1, 0, -1, -1);
        checkOutput("seq_done", 32'(saw_done), 32'd1);
        checkOutput("seq_valid_cycles", 32'(valid_cycles), 32'd48);
        checkOutput("seq_crc_cycles", 32'(crc_cycles), 32'd16);
        compareBits("seq_bits");
        checkResidual("seq_residual");

        // Same packet, strobe every third cycle with gapped tx_valid.
        applyStimulus(3, 0, -1, -1);
        checkOutput("slow_done", 32'(saw_done), 32'd1);
        checkOutput("slow_stability", 32'(stab_err), 32'd0);
        compareBits("slow_bits");

        // Single non-last byte then starvation.
        pkt_q = '{8'hA5}; mark_last = 0;
        applyStimulus(1, 0, -1, -1);
        checkOutput("urun_pulse", 32'(saw_underrun), 32'd1);
        checkOutput("urun_no_done", 32'(saw_done), 32'd0);
        checkOutput("urun_valid", 32'(tx_bit_valid), 32'd0);
        checkOutput("urun_nbits", 32'(got_q.size()), 32'd8);
        cap = 8'h00;
        for (int i = 0; i < 8 && i < got_q.size(); i++) cap[i] = got_q[i];
        checkOutput("urun_bits", 32'(cap), 32'hA5);
        @(negedge clk);
        checkOutput("urun_one_cycle", 32'(underrun), 32'd0);
        checkOutput("urun_ready", 32'(tx_ready), 32'd1);

        // Abort on CRC bit 5 together with a strobe.
        pkt_q = '{8'($urandom), 8'($urandom)}; mark_last = 1;
        applyStimulus(1, 0, 5, -1);
        checkOutput("abort_taken", 32'(saw_abort), 32'd1);
        checkOutput("abort_valid", 32'(tx_bit_valid), 32'd0);
        checkOutput("abort_crc_phase", 32'(crc_phase), 32'd0);
        checkOutput("abort_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("abort_crc", 32'(dut.crc_q), 32'hFFFF);
        checkOutput("abort_ready", 32'(tx_ready), 32'd1);
        dones = 0;
        bit_strobe = 1'b1;
        repeat (20) begin
            if (pkt_done) dones++;
            @(negedge clk);
        end
        bit_strobe = 1'b0;
        checkOutput("abort_no_done", 32'(dones), 32'd0);

        // Randomized packets after the abort.
        for (int p = 0; p < 4; p++) begin
            int len;
            len = $urandom_range(1, 6);
            pkt_q.delete();
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
            applyStimulus($urandom_range(1, 3), 0, -1, -1);
            checkOutput("rnd_done", 32'(saw_done), 32'd1);
            compareBits("rnd_bits");
            checkResidual("rnd_residual");
        end

`ifdef USB_CRC16_GEN_SELFCHECK_EN
        pkt_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        applyStimulus(1, 0, -1, -1);
        checkOutput("selfchk_clean", 32'(saw_selfchk), 32'd0);
        applyStimulus(1, 0, -1, 4);
        checkOutput("selfchk_flip_done", 32'(saw_done), 32'd1);
        checkOutput("selfchk_flip_err", 32'(saw_selfchk), 32'd1);
`endif

        // Asynchronous reset in the middle of a packet.
        tx_valid = 1'b1; tx_data = 8'h3C; tx_last = 1'b1; bit_strobe = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; tx_last = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_active", 32'(tx_bit_valid), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(tx_bit_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("mid_rst_bit", 32'(tx_bit), 32'd0);
        checkOutput("mid_rst_crc", 32'(dut.crc_q), 32'hFFFF);
        @(negedge clk);
        n_rst = 1'b1; bit_strobe = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
